ghost_mode_sched: RTL and testbench

//  Global ghost-behaviour sequencer. Steps all four ghosts through the timed SCATTER/CHASE

---
 rtl/pacman_pkg.sv | 25 ++
 rtl/ghost_mode_sched_downcounter.sv | 28 ++
 rtl/ghost_mode_sched.sv | 124 ++++++++++++
 tb/tb_ghost_mode_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared ghost-behaviour codes: movement modes and direction encodings used by the
// mode sequencer and the ghost movers.
package pacman_pkg;

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'b00,
        MODE_CHASE   = 2'b01,
        MODE_FRIGHT  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    localparam logic [2:0] LAST_PHASE = 3'd7;

    // Even schedule phases scatter, odd phases chase.
    function automatic mode_e phaseMode(input logic [2:0] ph);
        return ph[0] ? MODE_CHASE : MODE_SCATTER;
    endfunction

endpackage

// File: rtl/ghost_mode_sched_downcounter.sv
// Frame-tick down-counter: load wins over a tick; expire flags the tick that
// consumes the last remaining count.
module tick_downcounter #(
    parameter int unsigned        T_WIDTH   = 12,
    parameter logic [T_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [T_WIDTH-1:0] value,
    input  logic               tick,
    input  logic               en,
    output logic [T_WIDTH-1:0] count,
    output logic               expire
);

    assign expire = en && tick && (count == T_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset)
            count <= RESET_VAL;
        else if (load)
            count <= value;
        else if (en && tick)
            count <= count - T_WIDTH'(1);
    end

endmodule

// File: rtl/ghost_mode_sched.sv
// Global ghost mode sequencer: timed scatter/chase schedule, frightened override on
// power pellets, and a one-cycle reversal pulse on every mode change into a new regime.
module ghost_mode_sched
    import pacman_pkg::*;
#(
    parameter int unsigned T_WIDTH      = 12,
    parameter int unsigned SCATTER0     = 420,
    parameter int unsigned CHASE0       = 1200,
    parameter int unsigned SCATTER1     = 420,
    parameter int unsigned CHASE1       = 1200,
    parameter int unsigned SCATTER2     = 300,
    parameter int unsigned CHASE2       = 1200,
    parameter int unsigned SCATTER3     = 300,
    parameter int unsigned FRIGHT_TICKS = 360,
    parameter int unsigned FLASH_TICKS  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frameTick,
    input  logic       pause,
    input  logic       powerPellet,
    output logic [1:0] mode,
    output logic       reverseDir,
    output logic       flash,
    output logic [2:0] phase
);

    localparam logic [T_WIDTH-1:0] FRIGHT_LOAD = T_WIDTH'(FRIGHT_TICKS);
    localparam logic [T_WIDTH-1:0] FLASH_LIM   = T_WIDTH'(FLASH_TICKS);
    localparam logic [T_WIDTH-1:0] FIRST_LOAD  = T_WIDTH'(SCATTER0);

    localparam bit DUR_OK = (SCATTER0 != 0) && (CHASE0 != 0) && (SCATTER1 != 0) &&
                            (CHASE1 != 0) && (SCATTER2 != 0) && (CHASE2 != 0) &&
                            (SCATTER3 != 0) && (FRIGHT_TICKS != 0);

    mode_e              modeQ, modeNext;
    logic               flashNext;
    logic               live, inFright, pelletHit;
    logic               phaseEn, phaseExpire, frightEn, frightExpire;
    logic [2:0]         nextPhase;
    logic [T_WIDTH-1:0] phaseLoadVal, phaseCnt, frightCnt;

    assign mode      = modeQ;
    assign live      = !pause;
    assign inFright  = (modeQ == MODE_FRIGHT);
    assign pelletHit = live && powerPellet;
    assign nextPhase = phase + 3'd1;

    // The schedule clock stops for all of fright and never runs in the final phase.
    assign phaseEn  = live && !inFright && (phase != LAST_PHASE);
    assign frightEn = live && inFright;

    always_comb begin
        phaseLoadVal = '0;
        case (nextPhase)
            3'd1:    phaseLoadVal = T_WIDTH'(CHASE0);
            3'd2:    phaseLoadVal = T_WIDTH'(SCATTER1);
            3'd3:    phaseLoadVal = T_WIDTH'(CHASE1);
            3'd4:    phaseLoadVal = T_WIDTH'(SCATTER2);
            3'd5:    phaseLoadVal = T_WIDTH'(CHASE2);
            3'd6:    phaseLoadVal = T_WIDTH'(SCATTER3);
            default: phaseLoadVal = '0;
        endcase
    end

    tick_downcounter #(.T_WIDTH(T_WIDTH), .RESET_VAL(FIRST_LOAD)) uPhaseCnt (
        .clk    (clk),
        .reset  (reset),
        .load   (phaseExpire),
        .value  (phaseLoadVal),
        .tick   (frameTick),
        .en     (phaseEn),
        .count  (phaseCnt),
        .expire (phaseExpire)
    );

    tick_downcounter #(.T_WIDTH(T_WIDTH), .RESET_VAL('0)) uFrightCnt (
        .clk    (clk),
        .reset  (reset),
        .load   (pelletHit),
        .value  (FRIGHT_LOAD),
        .tick   (frameTick),
        .en     (frightEn),
        .count  (frightCnt),
        .expire (frightExpire)
    );

    // Flash tracks the post-edge fright count so it lands in the same cycle as mode.
    always_comb begin
        modeNext  = modeQ;
        flashNext = flash;
        if (pelletHit) begin
            modeNext  = MODE_FRIGHT;
            flashNext = (FRIGHT_LOAD <= FLASH_LIM);
        end else if (frightExpire) begin
            modeNext  = phaseMode(phase);
            flashNext = 1'b0;
        end else if (frightEn && frameTick) begin
            flashNext = ((frightCnt - T_WIDTH'(1)) <= FLASH_LIM);
        end else if (phaseExpire) begin
            modeNext  = phaseMode(nextPhase);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            modeQ      <= MODE_SCATTER;
            phase      <= 3'd0;
            reverseDir <= 1'b0;
            flash      <= 1'b0;
        end else if (pause) begin
            reverseDir <= 1'b0;
        end else begin
            modeQ      <= modeNext;
            reverseDir <= pelletHit || phaseExpire;
            flash      <= flashNext;
            if (phaseExpire)
                phase <= nextPhase;
        end
    end

    assert property (@(posedge clk) disable iff (reset) DUR_OK);

endmodule

// File: tb/tb_ghost_mode_sched.sv
// Bench for ghost_mode_sched with shortened durations; directed scenarios plus a
// randomized run against a tick-level behavioural model.
module tb_ghost_mode_sched;

    localparam int SC = 3;
    localparam int CH = 4;
    localparam int FR = 5;
    localparam int FL = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frameTick = 1'b0;
    logic       pause = 1'b0;
    logic       powerPellet = 1'b0;
    logic [1:0] mode;
    logic       reverseDir;
    logic       flash;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    int dur [7] = '{SC, CH, SC, CH, SC, CH, SC};
    int mMode, mPhase, mPhaseLeft, mFrightLeft;
    bit mRev, mFlash;

    ghost_mode_sched #(
        .T_WIDTH(12), .SCATTER0(SC), .CHASE0(CH), .SCATTER1(SC), .CHASE1(CH),
        .SCATTER2(SC), .CHASE2(CH), .SCATTER3(SC), .FRIGHT_TICKS(FR), .FLASH_TICKS(FL)
    ) dut (
        .clk(clk), .reset(reset), .frameTick(frameTick), .pause(pause),
        .powerPellet(powerPellet), .mode(mode), .reverseDir(reverseDir),
        .flash(flash), .phase(phase)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; the model advances by the same rules.
    task automatic cyc(input bit t, input bit p, input bit ps, input bit r);
        bit inF, adv;
        frameTick = t; powerPellet = p; pause = ps; reset = r;
        @(posedge clk); #1;
        frameTick = 0; powerPellet = 0; pause = 0; reset = 0;
        if (r) begin
            mMode = 0; mPhase = 0; mPhaseLeft = dur[0]; mFrightLeft = 0; mRev = 0; mFlash = 0;
        end else if (ps) begin
            mRev = 0;
        end else begin
            inF = (mMode == 2);
            adv = 0;
            if (!inF && mPhase < 7 && t) begin
                if (mPhaseLeft == 1) begin
                    adv = 1;
                    mPhase++;
                    if (mPhase < 7) mPhaseLeft = dur[mPhase];
                end else mPhaseLeft--;
            end
            if (p) begin
                mMode = 2; mFrightLeft = FR;
            end else if (inF && t) begin
                if (mFrightLeft == 1) begin
                    mFrightLeft = 0; mMode = mPhase % 2;
                end else mFrightLeft--;
            end else if (adv) mMode = mPhase % 2;
            mRev = p || adv;
            mFlash = (mMode == 2) && (mFrightLeft <= FL);
        end
    endtask

    // n frame ticks, each followed by a quiet cycle; returns reversal pulses seen.
    task automatic ticks(input int n, output int revs);
        revs = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0, 0); revs += reverseDir;
            cyc(0, 0, 0, 0); revs += reverseDir;
        end
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
        checks++; if (reverseDir !== 1'b0) begin errors++; $display("FAIL reset_rev got %0b want 0", reverseDir); end
        checks++; if (flash !== 1'b0) begin errors++; $display("FAIL reset_flash got %0b want 0", flash); end
    endtask

    task automatic test_phase_advance();
        int r;
        ticks(2, r);
        checks++; if (mode !== 2'b00 || phase !== 3'd0 || r != 0) begin errors++;
            $display("FAIL adv_early got mode=%0d phase=%0d revs=%0d want 0/0/0", mode, phase, r); end
        cyc(1, 0, 0, 0);
        checks++; if (mode !== 2'b01 || phase !== 3'd1 || reverseDir !== 1'b1) begin errors++;
            $display("FAIL adv_p1 got mode=%0d phase=%0d rev=%0b want 1/1/1", mode, phase, reverseDir); end
        cyc(0, 0, 0, 0);
        checks++; if (reverseDir !== 1'b0) begin errors++; $display("FAIL adv_pulse got %0b want 0", reverseDir); end
        ticks(3, r);
        checks++; if (phase !== 3'd1 || r != 0) begin errors++;
            $display("FAIL adv_hold got phase=%0d revs=%0d want 1/0", phase, r); end
        cyc(1, 0, 0, 0);
        checks++; if (mode !== 2'b00 || phase !== 3'd2 || reverseDir !== 1'b1) begin errors++;
            $display("FAIL adv_p2 got mode=%0d phase=%0d rev=%0b want 0/2/1", mode, phase, reverseDir); end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_phase7();
        int r, revs, n, bad;
        revs = 0; n = 0;
        while (phase !== 3'd7 && n < 60) begin ticks(1, r); revs += r; n++; end
        checks++; if (phase !== 3'd7 || mode !== 2'b01 || revs != 5 || n != 17) begin errors++;
            $display("FAIL p7_reach got phase=%0d mode=%0d revs=%0d ticks=%0d want 7/1/5/17", phase, mode, revs, n); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1, 0, 0, 0);
            if (phase !== 3'd7 || mode !== 2'b01 || reverseDir !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL p7_hold got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_fright();
        int r;
        cyc(0, 0, 0, 1);
        ticks(3, r); ticks(2, r);
        cyc(0, 1, 0, 0);
        checks++; if (mode !== 2'b10 || reverseDir !== 1'b1 || flash !== 1'b0) begin errors++;
            $display("FAIL fr_enter got mode=%0d rev=%0b flash=%0b want 2/1/0", mode, reverseDir, flash); end
        ticks(2, r);
        checks++; if (flash !== 1'b0 || mode !== 2'b10 || r != 0) begin errors++;
            $display("FAIL fr_noflash got flash=%0b mode=%0d revs=%0d want 0/2/0", flash, mode, r); end
        ticks(1, r);
        checks++; if (flash !== 1'b1 || mode !== 2'b10) begin errors++;
            $display("FAIL fr_flash got flash=%0b mode=%0d want 1/2", flash, mode); end
        ticks(1, r);
        cyc(1, 0, 0, 0);
        checks++; if (mode !== 2'b01 || phase !== 3'd1 || reverseDir !== 1'b0 || flash !== 1'b0) begin errors++;
            $display("FAIL fr_exit got mode=%0d phase=%0d rev=%0b flash=%0b want 1/1/0/0", mode, phase, reverseDir, flash); end
        cyc(0, 0, 0, 0);
        ticks(1, r);
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL fr_resume1 got phase=%0d want 1", phase); end
        ticks(1, r);
        checks++; if (phase !== 3'd2 || mode !== 2'b00 || r != 1) begin errors++;
            $display("FAIL fr_resume2 got phase=%0d mode=%0d revs=%0d want 2/0/1", phase, mode, r); end
    endtask

    task automatic test_simul();
        int r;
        cyc(0, 0, 0, 1);
        ticks(2, r);
        cyc(1, 1, 0, 0);
        checks++; if (phase !== 3'd1 || mode !== 2'b10 || reverseDir !== 1'b1) begin errors++;
            $display("FAIL sim_phexp got phase=%0d mode=%0d rev=%0b want 1/2/1", phase, mode, reverseDir); end
        cyc(0, 0, 0, 0);
        checks++; if (reverseDir !== 1'b0) begin errors++; $display("FAIL sim_phexp_once got %0b want 0", reverseDir); end
        ticks(5, r);
        cyc(1, 1, 0, 0);
        checks++; if (mode !== 2'b10 || reverseDir !== 1'b1) begin errors++;
            $display("FAIL sim_tick_pel got mode=%0d rev=%0b want 2/1", mode, reverseDir); end
        cyc(0, 0, 0, 0);
        ticks(4, r);
        checks++; if (mode !== 2'b10 || r != 0) begin errors++;
            $display("FAIL sim_tick_pel_len got mode=%0d revs=%0d want 2/0", mode, r); end
        ticks(1, r);
        checks++; if (mode !== 2'b01 || phase !== 3'd1) begin errors++;
            $display("FAIL sim_tick_pel_exit got mode=%0d phase=%0d want 1/1", mode, phase); end
        cyc(0, 1, 0, 0); ticks(4, r);
        cyc(0, 1, 0, 0);
        checks++; if (mode !== 2'b10 || reverseDir !== 1'b1) begin errors++;
            $display("FAIL sim_retrig got mode=%0d rev=%0b want 2/1", mode, reverseDir); end
        ticks(4, r);
        checks++; if (mode !== 2'b10 || flash !== 1'b1) begin errors++;
            $display("FAIL sim_retrig_len got mode=%0d flash=%0b want 2/1", mode, flash); end
        cyc(1, 1, 0, 0);
        checks++; if (mode !== 2'b10 || reverseDir !== 1'b1 || flash !== 1'b0) begin errors++;
            $display("FAIL sim_exp_pel got mode=%0d rev=%0b flash=%0b want 2/1/0", mode, reverseDir, flash); end
        cyc(0, 0, 0, 0);
        ticks(4, r);
        checks++; if (mode !== 2'b10) begin errors++; $display("FAIL sim_exp_pel_len got mode=%0d want 2", mode); end
        ticks(1, r);
        checks++; if (mode !== 2'b01) begin errors++; $display("FAIL sim_exp_pel_exit got mode=%0d want 1", mode); end
    endtask

    task automatic test_pause();
        int r, bad;
        logic [5:0] snap;
        cyc(0, 0, 0, 1);
        ticks(3, r); ticks(1, r);
        snap = {mode, phase, flash};
        bad = 0;
        for (int i = 0; i < 22; i++) begin
            cyc(i % 2 == 0, i == 7, 1, 0);
            if ({mode, phase, flash} !== snap || reverseDir !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pause_hold got %0d bad cycles want 0", bad); end
        ticks(2, r);
        checks++; if (phase !== 3'd1 || mode !== 2'b01) begin errors++;
            $display("FAIL pause_resume got phase=%0d mode=%0d want 1/1", phase, mode); end
        ticks(1, r);
        checks++; if (phase !== 3'd2 || r != 1) begin errors++;
            $display("FAIL pause_expire got phase=%0d revs=%0d want 2/1", phase, r); end
        cyc(0, 1, 0, 0); ticks(1, r);
        for (int i = 0; i < 22; i++) cyc(i % 2 == 0, 0, 1, 0);
        ticks(2, r);
        checks++; if (mode !== 2'b10 || flash !== 1'b1) begin errors++;
            $display("FAIL pause_fright got mode=%0d flash=%0b want 2/1", mode, flash); end
        ticks(2, r);
        checks++; if (mode !== 2'b00 || phase !== 3'd2) begin errors++;
            $display("FAIL pause_fright_exit got mode=%0d phase=%0d want 0/2", mode, phase); end
    endtask

    task automatic test_reset_mid();
        int r;
        ticks(3, r);
        cyc(0, 1, 0, 0); ticks(3, r);
        checks++; if (flash !== 1'b1) begin errors++; $display("FAIL rst_pre_flash got %0b want 1", flash); end
        cyc(1, 1, 0, 1);
        checks++; if (mode !== 2'b00 || phase !== 3'd0 || flash !== 1'b0 || reverseDir !== 1'b0) begin errors++;
            $display("FAIL rst_mid got mode=%0d phase=%0d flash=%0b rev=%0b want 0/0/0/0", mode, phase, flash, reverseDir); end
    endtask

    task automatic test_random();
        bit t, p, ps, r;
        int shown = 0;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom % 400) == 0;
            t  = ($urandom % 3) == 0;
            p  = ($urandom % 30) == 0;
            ps = ($urandom % 10) == 0;
            cyc(t, p, ps, r);
            checks++;
            if (mode !== 2'(mMode) || phase !== 3'(mPhase) || reverseDir !== mRev || flash !== mFlash) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL rand_cycle%0d got m=%0d ph=%0d rev=%0b fl=%0b want m=%0d ph=%0d rev=%0b fl=%0b",
                             i, mode, phase, reverseDir, flash, mMode, mPhase, mRev, mFlash);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_phase_advance();
        test_phase7();
        test_fright();
        test_simul();
        test_pause();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
